// File: rtl/noc_flit_tx.sv
// Read-side drain engine: pops flits from a FIFO and drives them onto a valid/ready link with
// head/tail framing flags. Optional stall watchdog enabled by defining NOC_TX_TIMEOUT_EN.
module noc_flit_tx #(
  parameter int unsigned FLIT_W         = 8,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [FLIT_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic [FLIT_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_head,
  output logic              tx_tail,
  output logic              pkt_done,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              tx_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || FLIT_W < 4) begin : gen_param_err
    $error("noc_flit_tx: TIMEOUT_CYCLES must be 1..65535 and FLIT_W at least 4");
  end

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StSend} state_e;

  state_e            state_q, state_d;
  logic [FLIT_W-1:0] data_q, data_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic              first_q, first_d;   // next captured flit is a header
  logic [3:0]        remain_q, remain_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        len;

  assign len = fifo_data[3:0];

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    head_d   = head_q;
    tail_d   = tail_q;
    first_d  = first_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    count_d  = count_q;
    unique case (state_q)
      StIdle: begin
        if (en && !fifo_empty) state_d = StFetch;
      end
      StFetch: begin
        state_d = StLoad;
      end
      StLoad: begin
        data_d  = fifo_data;
        first_d = 1'b0;
        if (first_q) begin
          head_d   = 1'b1;
          remain_d = len;
          tail_d   = (len == 4'd0);
        end else begin
          head_d   = 1'b0;
          remain_d = remain_q - 4'd1;
          tail_d   = (remain_q == 4'd1);
        end
        state_d = StSend;
      end
      StSend: begin
        if (tx_ready) begin
          state_d = StIdle;
          if (tail_q) begin
            first_d = 1'b1;
            done_d  = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      data_q   <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      first_q  <= 1'b1;
      remain_q <= '0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      first_q  <= first_d;
      remain_q <= remain_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  // Gated by rst so a reset landing on FETCH/SEND never strobes the FIFO or the link.
  assign fifo_rd   = (state_q == StFetch) && !rst;
  assign tx_valid  = (state_q == StSend) && !rst;
  assign tx_data   = data_q;
  assign tx_head   = head_q;
  assign tx_tail   = tail_q;
  assign pkt_done  = done_q;
  assign pkt_count = count_q;

`ifdef NOC_TX_TIMEOUT_EN
  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYCLES);

  logic [15:0] stall_q, stall_d;
  logic        err_q, err_d;

  always_comb begin
    stall_d = '0;
    err_d   = err_q;
    // Counter saturates at the threshold; the flit stays held regardless.
    if (state_q == StSend && !tx_ready) begin
      stall_d = (stall_q == TimeoutVal) ? stall_q : stall_q + 16'd1;
    end
    if (stall_d == TimeoutVal) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign tx_err = err_q;
`else
  assign tx_err = 1'b0;
`endif

endmodule

// File: doc/noc_flit_tx.md
Name: noc_flit_tx

Overview:
- Read-side drain engine for an 8-bit NoC flit FIFO.
- Pops flits from the FIFO's read port and presents them on an outgoing router link using a valid/ready handshake.
- Tracks packet framing from the header flit and drives head/tail sideband flags.
- Sits between an input-port FIFO and the switch or output link of a router.

Parameters:
- FLIT_W, 8, flit width. Header length field is always bits [3:0].
- CNT_W, 16, width of the sent-packet counter.
- TIMEOUT_CYCLES, 64, stall threshold for the optional watchdog. Must be 1..65535.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  block enable; gates the start of new FIFO reads only
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  FLIT_W  FIFO read data, valid in the cycle after fifo_rd
- fifo_rd  out  1  FIFO read strobe, one-cycle pulse per flit
- tx_data  out  FLIT_W  link flit, registered
- tx_valid  out  1  link flit valid
- tx_ready  in  1  link accepts the flit
- tx_head  out  1  current tx_data is a header flit
- tx_tail  out  1  current tx_data is the last flit of its packet
- pkt_done  out  1  one-cycle pulse when a tail flit is accepted
- pkt_count  out  CNT_W  number of completed packets, wraps
- tx_err  out  1  sticky stall error (watchdog)

Behaviour:
- Reset (synchronous, active-high, one clk): state=IDLE. All outputs 0: fifo_rd, tx_data, tx_valid, tx_head, tx_tail, pkt_done, pkt_count, tx_err. Next flit is treated as a header; remaining-flit counter cleared.
- Reset mid-operation: any partial packet or held flit is abandoned, and no fifo_rd is issued in the reset cycle.
- FSM states: IDLE, FETCH, LOAD, SEND.
  - IDLE: go to FETCH when en=1 and fifo_empty=0; otherwise stay.
  - FETCH: fifo_rd=1 for this cycle only, then go to LOAD.
  - LOAD: capture fifo_data into tx_data on the edge ending LOAD. Set tx_head/tx_tail from framing state, then go to SEND.
  - SEND: tx_valid=1; tx_data, tx_head and tx_tail are held stable. On an edge with tx_ready=1 the flit transfers: tx_valid drops next cycle and state returns to IDLE.
- fifo_rd is a Moore output (state==FETCH). It is never asserted while fifo_empty=0 is unverified; the FIFO guarantees data for one read when not empty.
- Latency: fifo_empty sampled 0 in IDLE → tx_valid high 3 cycles later. Throughput is at most one flit per 4 cycles with tx_ready tied high.
- Framing:
  - Header flit: tx_head=1; remaining = data[3:0] payload flits.
  - Header with length 0: tx_head=1 and tx_tail=1.
  - Payload flit: remaining decrements on capture; tx_tail=1 when remaining reaches 0.
  - After a tail transfers, the next flit is a header.
- pkt_done pulses for one cycle on the edge where a tail flit handshakes. pkt_count increments on that same edge and wraps from 2^CNT_W-1 to 0.
- FIFO goes empty mid-packet: wait in IDLE; framing state is retained.
- en=0: no new FETCH. A flit already in FETCH/LOAD/SEND completes normally.
- tx_ready high while tx_valid=0: ignored.
- No flit is ever dropped or duplicated.

Optional Feature:
- Macro: NOC_TX_TIMEOUT_EN.
- When defined:
  - A stall counter increments each cycle in SEND with tx_ready=0, and clears on handshake or when not in SEND.
  - When the counter reaches TIMEOUT_CYCLES, tx_err is set and stays 1 until rst.
  - The flit remains held; there is no drop.
- When undefined: no counter logic; tx_err is tied to 0.

Test Plan:
- Reset check: rst for 1 cycle with fifo_empty=0 → all outputs 0 and fifo_rd=0 during reset. First fifo_rd occurs 1 cycle after rst falls.
- Single packet: FIFO holds 8'h02, 8'hA1, 8'hA2; tx_ready=1 → flits sent in order with tx_head only on 8'h02 and tx_tail only on 8'hA2. pkt_done pulses once; pkt_count=1.
- Zero-length header and back-to-back: FIFO holds 8'h00, 8'h01, 8'h55 → first flit has head=tail=1. Second packet sends 8'h01 (head) then 8'h55 (tail); pkt_count=2.
- Backpressure: tx_ready=0 for 10 cycles during SEND → tx_data stable, no extra fifo_rd. The flit transfers on the first ready edge and exactly one handshake is counted.
- Empty mid-packet and en gating:
  - Header 8'h03 with only 1 payload queued → block idles with no fifo_rd. Pushing 2 more flits completes the packet with tail on the third payload.
  - en=0 with FIFO non-empty → no fifo_rd issued.
- Watchdog (NOC_TX_TIMEOUT_EN, TIMEOUT_CYCLES=8): hold tx_ready=0 → tx_err rises after 8 stalled cycles and stays 1 after the handshake, until rst. Without the macro, tx_err stays 0.
